// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with per-entry saturating counters and stats
module branch_target_predictor #(
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              ex_mispredict,
    input  logic              bp_flush,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;
    localparam logic [STAT_W-1:0]   STAT_MAX    = '1;

    logic                entry_valid  [ENTRIES];
    logic [TAG_BITS-1:0] entry_tag    [ENTRIES];
    logic [ADDR_W-1:0]   entry_target [ENTRIES];
    logic [CNT_BITS-1:0] entry_cnt    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] ex_tag;
    logic                if_hit;
    logic                ex_hit;
    logic                unused_ex_pc;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // ex_pc only contributes its index and tag bits
    assign unused_ex_pc = ^{ex_pc[1:0], ex_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2]};

    // Lookup reads the registered table, so a same-cycle update is not visible yet
    assign if_hit      = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    assign ex_hit      = entry_valid[ex_idx] && (entry_tag[ex_idx] == ex_tag);
    assign pred_taken  = if_hit && entry_cnt[if_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? entry_target[if_idx] : if_pc + ADDR_W'(4);

    assign ex_mispredict = ex_valid &&
                           ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target)));

    // Table update from the resolving branch; flush wins and blocks allocation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_cnt[i]    <= CNT_WEAK_NT;
            end
        end else if (bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= 1'b0;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    entry_target[ex_idx] <= ex_target;
                    if (entry_cnt[ex_idx] != CNT_MAX) begin
                        entry_cnt[ex_idx] <= entry_cnt[ex_idx] + CNT_BITS'(1);
                    end
                end else if (entry_cnt[ex_idx] != '0) begin
                    entry_cnt[ex_idx] <= entry_cnt[ex_idx] - CNT_BITS'(1);
                end
            end else if (ex_taken) begin
                entry_valid[ex_idx]  <= 1'b1;
                entry_tag[ex_idx]    <= ex_tag;
                entry_target[ex_idx] <= ex_target;
                entry_cnt[ex_idx]    <= CNT_WEAK_T;
            end
        end
    end

    // Saturating statistics; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (stat_clear) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (ex_valid && (stat_branches != STAT_MAX)) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (ex_mispredict && (stat_mispred != STAT_MAX)) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - vector table, directed corners and random checks against a model
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        bp_flush = 1'b0;
    logic        stat_clear = 1'b0;

    logic        pred_taken, pred_taken4;
    logic [31:0] pred_target, pred_target4;
    logic        ex_mispredict, ex_mispredict4;
    logic [31:0] stat_branches, stat_mispred;
    logic [3:0]  stat_branches4, stat_mispred4;

    int compared = 0;
    int mismatched = 0;

    branch_target_predictor dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_mispredict(ex_mispredict), .bp_flush(bp_flush), .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_target_predictor #(.STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken4), .pred_target(pred_target4),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_mispredict(ex_mispredict4), .bp_flush(bp_flush), .stat_clear(stat_clear),
        .stat_branches(stat_branches4), .stat_mispred(stat_mispred4)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, counters as plain integers
    bit          mv   [32];
    int          mtag [32];
    logic [31:0] mtgt [32];
    int          mcnt [32];
    longint      br, mp, br4, mp4;
    localparam longint CAP32 = 64'hFFFF_FFFF;
    localparam longint CAP4  = 15;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'(pc / 4) % 32;
    endfunction

    function automatic int tagof(input logic [31:0] pc);
        return int'(pc / 128) % 256;
    endfunction

    function automatic void mpred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i  = slot(pc);
        t  = mv[i] && (mtag[i] == tagof(pc)) && (mcnt[i] >= 2);
        tg = t ? mtgt[i] : pc + 32'd4;
    endfunction

    function automatic logic mmis();
        if (!ex_valid) return 1'b0;
        if (ex_taken != ex_pred_taken) return 1'b1;
        return ex_taken && (ex_target != ex_pred_target);
    endfunction

    function automatic void mreset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = '0; mcnt[i] = 1;
        end
        br = 0; mp = 0; br4 = 0; mp4 = 0;
    endfunction

    function automatic void mupdate(input logic mis);
        int i;
        bit hit;
        i   = slot(ex_pc);
        hit = mv[i] && (mtag[i] == tagof(ex_pc));
        if (bp_flush) begin
            for (int k = 0; k < 32; k++) mv[k] = 0;
        end else if (ex_valid) begin
            if (hit && ex_taken) begin
                mcnt[i] = (mcnt[i] < 3) ? mcnt[i] + 1 : 3;
                mtgt[i] = ex_target;
            end else if (hit) begin
                mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
            end else if (ex_taken) begin
                mv[i] = 1; mtag[i] = tagof(ex_pc); mtgt[i] = ex_target; mcnt[i] = 2;
            end
        end
        if (stat_clear) begin
            br = 0; mp = 0; br4 = 0; mp4 = 0;
        end else begin
            if (ex_valid) begin
                if (br < CAP32) br++;
                if (br4 < CAP4) br4++;
            end
            if (mis) begin
                if (mp < CAP32) mp++;
                if (mp4 < CAP4) mp4++;
            end
        end
    endfunction

    // Inputs are already driven just after a falling edge
    task automatic cycle();
        logic        et;
        logic [31:0] etg;
        logic        mis;
        #1;
        mpred(if_pc, et, etg);
        mis = mmis();
        chk("model_pred_taken", pred_taken, et);
        chk("model_pred_target", pred_target, etg);
        chk("model_mispredict", ex_mispredict, mis);
        chk("model_stat_branches", stat_branches, br);
        chk("model_stat_mispred", stat_mispred, mp);
        chk("model_stat_branches4", stat_branches4, br4);
        chk("model_stat_mispred4", stat_mispred4, mp4);
        @(posedge clk);
        mupdate(mis);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                         input logic et, input logic [31:0] etg, input logic ept,
                         input logic [31:0] eptg, input logic fl, input logic cl);
        if_pc = ipc; ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg;
        ex_pred_taken = ept; ex_pred_target = eptg; bp_flush = fl; stat_clear = cl;
    endtask

    typedef struct {
        logic [31:0] ipc;
        logic        ev;
        logic [31:0] epc;
        logic        et;
        logic [31:0] etg;
        logic        ept;
        logic [31:0] eptg;
        logic        fl;
        logic        x_pt;
        logic [31:0] x_ptg;
        logic        x_mis;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic        t;
        logic [31:0] tg;
        logic [31:0] a_pc, a_epc;
        mreset();
        //               if_pc         ev  ex_pc   et  ex_tgt  ept ex_ptgt  fl  pt  ptgt          mis
        tbl[0]  = '{32'h100,       1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 0, 32'h104,      1};
        tbl[1]  = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h80,       0};
        tbl[2]  = '{32'h180,       1, 32'h180, 0, 32'h0,   0, 32'h184, 0, 0, 32'h184,      0};
        tbl[3]  = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h80,       0};
        tbl[4]  = '{32'h200,       1, 32'h200, 1, 32'h300, 1, 32'h300, 0, 0, 32'h204,      0};
        tbl[5]  = '{32'h200,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h300,      0};
        tbl[6]  = '{32'hFFFFFFFC,  1, 32'h200, 1, 32'h340, 1, 32'h300, 0, 0, 32'h0,        1};
        tbl[7]  = '{32'h200,       1, 32'h200, 0, 32'h0,   1, 32'h340, 0, 1, 32'h340,      1};
        tbl[8]  = '{32'h200,       1, 32'h200, 0, 32'h0,   1, 32'h340, 0, 1, 32'h340,      1};
        tbl[9]  = '{32'h200,       0, 32'h200, 1, 32'h999, 0, 32'h0,   0, 0, 32'h204,      0};
        tbl[10] = '{32'h200,       1, 32'h200, 1, 32'h340, 0, 32'h204, 0, 0, 32'h204,      1};
        tbl[11] = '{32'h200,       1, 32'h200, 1, 32'h340, 0, 32'h204, 0, 1, 32'h340,      1};
        tbl[12] = '{32'h200,       1, 32'h200, 1, 32'h340, 0, 32'h204, 0, 1, 32'h340,      1};
        tbl[13] = '{32'h200,       1, 32'h200, 0, 32'h0,   1, 32'h340, 0, 1, 32'h340,      1};
        tbl[14] = '{32'h200,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h340,      0};
        tbl[15] = '{32'h200,       1, 32'h400, 1, 32'h500, 1, 32'h500, 1, 1, 32'h340,      0};
        tbl[16] = '{32'h200,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h204,      0};
        tbl[17] = '{32'h400,       0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h404,      0};

        // Reset held for a couple of cycles; outputs checked while still in reset
        if_pc = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        chk("in_reset_pred_taken", pred_taken, 1'b0);
        chk("in_reset_pred_target", pred_target, 32'h104);
        reset = 1'b1;
        #1;
        chk("reset_stat_branches", stat_branches, 32'd0);
        chk("reset_stat_mispred", stat_mispred, 32'd0);

        // Directed vector table
        for (int v = 0; v < 18; v++) begin
            drive(tbl[v].ipc, tbl[v].ev, tbl[v].epc, tbl[v].et, tbl[v].etg,
                  tbl[v].ept, tbl[v].eptg, tbl[v].fl, 1'b0);
            #1;
            chk($sformatf("vec%0d_pred_taken", v), pred_taken, tbl[v].x_pt);
            chk($sformatf("vec%0d_pred_target", v), pred_target, tbl[v].x_ptg);
            chk($sformatf("vec%0d_mispredict", v), ex_mispredict, tbl[v].x_mis);
            if (v == 1) begin
                chk("after_first_stat_branches", stat_branches, 32'd1);
                chk("after_first_stat_mispred", stat_mispred, 32'd1);
            end
            cycle();
        end

        // Random traffic over a few aliasing slots
        for (int n = 0; n < 3000; n++) begin
            a_pc  = (32'($urandom_range(1, 4)) << 7) | (32'($urandom_range(0, 3)) << 2) |
                    32'($urandom_range(0, 3));
            a_epc = (32'($urandom_range(1, 4)) << 7) | (32'($urandom_range(0, 3)) << 2) |
                    32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a_pc = $urandom;
            drive(a_pc, 1'($urandom_range(0, 3) != 0), a_epc, 1'($urandom),
                  32'($urandom_range(0, 7)) << 4, 1'b0, 32'h0,
                  1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 1) == 1) begin
                mpred(a_epc, t, tg);
                ex_pred_taken = t; ex_pred_target = tg;
            end else begin
                ex_pred_taken = 1'($urandom); ex_pred_target = 32'($urandom_range(0, 7)) << 4;
            end
            cycle();
        end

        // Narrow statistics saturate instead of wrapping
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
        cycle();
        for (int n = 0; n < 20; n++) begin
            drive(32'h100, 1, 32'h700, 0, 32'h0, 0, 32'h0, 0, 0);
            cycle();
        end
        chk("stat4_saturated", stat_branches4, 4'd15);
        chk("stat32_twenty", stat_branches, 32'd20);
        drive(32'h100, 1, 32'h700, 1, 32'h0, 0, 32'h0, 0, 1);
        cycle();
        chk("clear_beats_incr", stat_branches4, 4'd0);

        // Asynchronous reset in the middle of an update
        drive(32'h200, 1, 32'h200, 1, 32'h340, 0, 32'h0, 0, 0);
        cycle();
        cycle();
        chk("pre_reset_hit", pred_taken, 1'b1);
        drive(32'h200, 1, 32'h600, 1, 32'h700, 0, 32'h0, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_pred_taken", pred_taken, 1'b0);
        chk("async_reset_pred_target", pred_target, 32'h204);
        chk("async_reset_stat_branches", stat_branches, 32'd0);
        chk("async_reset_stat_mispred", stat_mispred, 32'd0);
        chk("async_reset_mispredict_eq", ex_mispredict, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mreset();
        drive(32'h600, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        #1;
        chk("discarded_alloc", pred_taken, 1'b0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
